// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings for the EX-stage divide issue controller.
package div_issue_ctrl_pkg;

    // in_op encodings: bit1 selects remainder, bit0 selects unsigned
    localparam logic [1:0] OP_DIV_W  = 2'b00;
    localparam logic [1:0] OP_DIV_WU = 2'b01;
    localparam logic [1:0] OP_MOD_W  = 2'b10;
    localparam logic [1:0] OP_MOD_WU = 2'b11;

    // controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // accept edge to result edge for a non-zero divisor
    localparam int DIV_LATENCY = 34;

    function automatic logic op_is_mod(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Sequences the shared iterative divider for div/mod ops: latches operands,
// short-circuits divide-by-zero, holds the result until the consumer takes it.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int          DEST_W = 5,
    parameter logic [31:0] ZERO_Q = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [31:0]       in_src1,
    input  logic [31:0]       in_src2,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              busy,
    output logic              div_en,
    output logic              div_signed,
    output logic [31:0]       div_x,
    output logic [31:0]       div_y,
    input  logic [31:0]       div_q,
    input  logic [31:0]       div_r,
    input  logic              div_complete
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        mod_q;
    logic        sgn_q;
    logic [31:0] x_q;
    logic [31:0] y_q;
    logic        accept;
    logic        src2_zero;
    logic        complete;
    logic        out_fire;

    assign in_ready  = (state == ST_IDLE) & ~flush;
    assign accept    = in_valid & in_ready;
    assign src2_zero = (in_src2 == 32'd0);
    // div_complete reads 1 whenever div is low, so only trust it under div_en
    assign complete  = div_en & div_complete;
    assign out_fire  = out_valid & out_ready;

    assign div_en     = (state == ST_BUSY);
    assign out_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
    // divider sign correction samples x/y at completion, so drive from latches
    assign div_x      = x_q;
    assign div_y      = y_q;
    assign div_signed = sgn_q;

    // next-state: flush overrides everything and forces a div-low cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)   state_nxt = src2_zero ? ST_DONE : ST_BUSY;
            ST_BUSY: if (complete) state_nxt = ST_DONE;
            ST_DONE: if (out_fire) state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // operand latch, held for the whole op
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q   <= 32'd0;
            y_q   <= 32'd0;
            sgn_q <= 1'b0;
            mod_q <= 1'b0;
        end else if (accept) begin
            x_q   <= in_src1;
            y_q   <= in_src2;
            sgn_q <= op_is_signed(in_op);
            mod_q <= op_is_mod(in_op);
        end
    end

    // result/tag capture: zero divisor resolves at accept, else at completion
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_result <= 32'd0;
            out_dest   <= '0;
        end else if (accept) begin
            out_dest <= in_dest;
            if (src2_zero) out_result <= op_is_mod(in_op) ? in_src1 : ZERO_Q;
        end else if (complete && !flush) begin
            out_result <= mod_q ? div_r : div_q;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a cycle-accurate divider stand-in.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    localparam int          DEST_W = 5;
    localparam logic [31:0] ZERO_Q = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_op = 2'b00;
    logic [31:0]       in_src1 = 32'd0;
    logic [31:0]       in_src2 = 32'd0;
    logic [DEST_W-1:0] in_dest = '0;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [DEST_W-1:0] out_dest;
    logic              busy;
    logic              div_en;
    logic              div_signed;
    logic [31:0]       div_x;
    logic [31:0]       div_y;
    logic [31:0]       div_q;
    logic [31:0]       div_r;
    logic              div_complete;

    div_issue_ctrl #(.DEST_W(DEST_W), .ZERO_Q(ZERO_Q)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest), .busy(busy),
        .div_en(div_en), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
        .div_q(div_q), .div_r(div_r), .div_complete(div_complete)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // divider stand-in: init cycle then 32 iterations, done in 34th div-high cycle
    logic [5:0] dcnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn)                    dcnt <= 6'd0;
        else if (div_en & div_complete) dcnt <= 6'd0;
        else if (div_en)                dcnt <= dcnt + 6'd1;
        else                            dcnt <= 6'd0;
    end
    assign div_complete = ~div_en | (dcnt == 6'd33);

    always_comb begin
        div_q = 32'd0;
        div_r = 32'd0;
        if (div_y != 32'd0) begin
            if (div_signed) begin
                if (div_x == 32'h8000_0000 && div_y == 32'hFFFF_FFFF) begin
                    div_q = 32'h8000_0000;
                    div_r = 32'd0;
                end else begin
                    div_q = $signed(div_x) / $signed(div_y);
                    div_r = $signed(div_x) % $signed(div_y);
                end
            end else begin
                div_q = div_x / div_y;
                div_r = div_x % div_y;
            end
        end
    end

    typedef struct {
        logic [31:0]       res;
        logic [DEST_W-1:0] dest;
        int                acc;
        int                lat;
        logic [31:0]       a;
        logic [31:0]       b;
        logic              sgn;
    } exp_t;

    exp_t sbq[$];
    int   checks;
    int   errors;
    int   rdy_mode = 0;   // 0 always ready, 1 never, 2 random
    logic prev_valid = 1'b0;

    // reference: truncating division on 64-bit integers
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint av, bv, q, r;
        if (b == 32'd0) return op[1] ? a : ZERO_Q;
        if (!op[0]) begin
            av = longint'($signed(a));
            bv = longint'($signed(b));
        end else begin
            av = longint'({32'd0, a});
            bv = longint'({32'd0, b});
        end
        q = av / bv;
        r = av % bv;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon();
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (out_valid) begin
                    chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
                    if (sbq.size() == 0) begin
                        chk("unexpected_out_valid", 32'd1, 32'd0);
                    end else begin
                        if (!prev_valid) chk("latency", cyc - sbq[0].acc, sbq[0].lat);
                        if (out_ready) begin
                            chk("out_result", out_result, sbq[0].res);
                            chk("out_dest", {27'd0, out_dest}, {27'd0, sbq[0].dest});
                            void'(sbq.pop_front());
                        end
                    end
                end
                if (div_en) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_div_en", 32'd1, 32'd0);
                    end else begin
                        chk("div_x_stable", div_x, sbq[0].a);
                        chk("div_y_stable", div_y, sbq[0].b);
                        chk("div_signed", {31'd0, div_signed}, {31'd0, sbq[0].sgn});
                        chk("div_en_nonzero_divisor", {31'd0, sbq[0].b != 32'd0}, 32'd1);
                    end
                end
            end
            prev_valid = resetn & out_valid;
        end
    endtask

    task automatic rdy_drv();
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [DEST_W-1:0] d);
        int   n = 0;
        bit   got = 0;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_dest = d;
        while (!got && n < 300) begin
            @(negedge clk);
            if (in_ready) got = 1;
            else n++;
        end
        if (!got) begin
            chk("issue_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.res = ref_res(op, a, b); e.dest = d; e.acc = cyc;
        e.lat = (b == 32'd0) ? 0 : DIV_LATENCY;
        e.a = a; e.b = b; e.sgn = ~op[0];
        sbq.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic rand_op(output logic [1:0] op, output logic [31:0] a, output logic [31:0] b);
        int k;
        op = 2'($urandom_range(0, 3));
        k = $urandom_range(0, 9);
        a = (k < 2) ? 32'h8000_0000 : $urandom;
        k = $urandom_range(0, 9);
        if (k < 2)      b = 32'd0;
        else if (k < 4) b = 32'($urandom_range(1, 20));
        else if (k < 5) b = 32'hFFFF_FFFF;
        else            b = $urandom;
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b, hexp;
        int          n;
        checks = 0;
        errors = 0;
        fork
            mon();
            rdy_drv();
        join_none

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_div_en", {31'd0, div_en}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_dest", {27'd0, out_dest}, 32'd0);
        chk("rst_div_x", div_x, 32'd0);
        chk("rst_div_y", div_y, 32'd0);
        chk("rst_div_signed", {31'd0, div_signed}, 32'd0);
        resetn = 1'b1;

        // directed arithmetic cases
        issue(OP_DIV_W, 32'd7, 32'hFFFF_FFFE, 5'd3);
        drain();
        issue(OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 5'd1);
        issue(OP_MOD_WU, 32'hFFFF_FFFF, 32'd2, 5'd2);
        issue(OP_DIV_WU, 32'hFFFF_FFFF, 32'd2, 5'd4);
        issue(OP_DIV_W, 32'd5, 32'd0, 5'd6);
        issue(OP_MOD_WU, 32'd5, 32'd0, 5'd7);
        issue(OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        drain();

        // flush in the 10th busy cycle
        issue(OP_DIV_W, 32'h1234_5678, 32'd3, 5'd5);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_div_en", {31'd0, div_en}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        issue(OP_DIV_WU, 32'd100, 32'd7, 5'd9);
        drain();

        // back-pressure in DONE
        rdy_mode = 1;
        issue(OP_DIV_W, 32'd1234567, 32'd321, 5'd10);
        hexp = ref_res(OP_DIV_W, 32'd1234567, 32'd321);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("hold_wait_timeout", 32'd1, 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_out_result", out_result, hexp);
            chk("hold_out_dest", {27'd0, out_dest}, 32'd10);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        drain();

        // reset during busy
        issue(OP_DIV_W, 32'd1000, 32'd7, 5'd4);
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_div_en", {31'd0, div_en}, 32'd0);
        chk("mid_rst_out_result", out_result, 32'd0);
        chk("mid_rst_out_dest", {27'd0, out_dest}, 32'd0);
        chk("mid_rst_div_x", div_x, 32'd0);
        chk("mid_rst_div_y", div_y, 32'd0);
        chk("mid_rst_div_signed", {31'd0, div_signed}, 32'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // randomized traffic with random back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            rand_op(op, a, b);
            issue(op, a, b, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rdy_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
